pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that supersedes the fixed per-stage latch registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single reusable block. It carries a control bundle and a data bundle between adjacent stages and adds a valid/ready handshake, back-pressure (stall), synchronous flush with bubble insertion, and an optional skid entry that registers the upstream ready path. A saturating stall counter supports hazard-rate profiling. Instances sit between every pair of CPU pipeline stages.

## Interface
- CTRL_W, 9: control bundle width (WB/M/EX control bits); forced to zero on any bubble.
- DATA_W, 128: data bundle width (operands, immediate, register addresses); never cleared except by reset.
- SKID, 0: 0 gives a single entry with combinational in_ready; 1 gives main plus skid entry with registered in_ready.
- CNT_W, 16: stall counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of all held beats (branch/exception).
- out_valid  out  1  a beat is presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bundle; 0 whenever out_valid=0.
- out_data  out  DATA_W  data bundle; don't-care when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
- SKID=0: in_ready = !out_valid || out_ready. On an input transfer the register loads in_ctrl/in_data and sets valid. On an output transfer with no input transfer, valid clears and ctrl zeroes.
- SKID=1: entries main (drives outputs) and skid. in_ready = !skid_valid (registered).
  - Input transfer while main is empty, or main is draining this cycle: load main.
  - Input transfer while main is full and stalled: load skid.
  - Output transfer with skid full: skid moves to main and skid empties.
  - Ordering is strict FIFO; no beat is dropped or duplicated.
- flush=1: on that edge all valid bits clear and all ctrl fields zero. Flush wins over a simultaneous input transfer, so the incoming beat is discarded. in_ready does not depend on flush.
- stall_cnt increments on each cycle with out_valid && !out_ready. It saturates at 2^CNT_W-1. stall_clr wins over increment.
- Data fields of empty entries hold their last value; only ctrl is zeroed, so an empty stage acts as a NOP.

## Timing
- Reset (async assert, sync release to next edge): out_valid=0, out_ctrl=0, out_data=0, skid cleared, stall_cnt=0. in_ready=1 during reset for both SKID settings.
- Latency: 1 cycle from input transfer to out_valid for both SKID settings.
- Throughput: 1 beat/cycle when out_ready is held high.
- SKID=1: in_ready falls the cycle after the skid entry loads. At most one extra beat is accepted after out_ready drops.
- Simultaneous input and output transfer with SKID=0: the register reloads and out_valid stays 1.
- Reset asserted mid-stream: all held beats are lost and outputs are at reset values immediately (asynchronous).
- stall_cnt updates on the edge following the stalled cycle.

## Test plan
- Streaming, SKID=0: in_valid=1 and out_ready=1 for 8 cycles with data 0..7 → out_data 0..7 one cycle later, out_valid stays 1, stall_cnt=0.
- Back-pressure, SKID=1: stream 1,2,3 and drop out_ready after beat 1 appears → beat 2 in main, beat 3 in skid, in_ready=0. Restore out_ready → 2 then 3 in order, no loss.
- Flush collision: beat A held, then flush=1 with in_valid=1 carrying B → next cycle out_valid=0, out_ctrl=0, B never appears.
- Bubble: in_valid=0 with in_ctrl=9'h1FF → out_ctrl=0 and out_valid=0.
- Counter, CNT_W=2: hold a beat with out_ready=0 for 5 cycles → stall_cnt reads 1, 2, 3, 3, 3. Then stall_clr → 0.
- Async reset mid-stall: drop rst_n between clock edges → out_valid=0, stall_cnt=0, in_ready=1 with no clock edge required.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline stage register carrying a control and a
// data bundle with valid/ready handshake, stall back-pressure, flush with
// bubble insertion, an optional skid entry and a saturating stall counter.
// Empty entries always hold a zero control bundle so that an empty stage
// behaves as a NOP downstream; data bundles are only cleared by reset.
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 128,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic              in_xfer;
    logic              out_xfer;

    // With a skid entry, in_ready comes straight from a flop so the upstream
    // ready path is cut; without it, a full stage accepts only while draining.
    assign in_ready  = (SKID != 0) ? !skid_valid_q : (!main_valid_q || out_ready);
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state for the main/skid entries; flush overrides any transfer.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        in_xfer      = in_valid && in_ready;
        out_xfer     = main_valid_q && out_ready;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (SKID == 0) begin
            if (in_xfer) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else if (out_xfer) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else begin
            // in_ready is low while the skid entry is full, so a skid refill
            // of main never coincides with an input transfer.
            if (out_xfer && skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (in_xfer && (!main_valid_q || out_xfer)) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end else if (out_xfer) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end
    end

    // Saturating count of cycles where a beat is presented but not taken.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops every held beat and clears all fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: one instance without skid (2-bit stall
// counter) and one with skid (4-bit stall counter) share the same stimulus.
// A FIFO-queue reference model tracks each instance.
module tb_pipe_stage_reg;

    localparam int CW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          stall_clr = 1'b0;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    stall_cnt0;
    logic [3:0]    stall_cnt1;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .stall_cnt(stall_cnt0), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .stall_cnt(stall_cnt1), .stall_clr(stall_clr)
    );

    // Reference model: each stage is a FIFO of capacity 1 (no skid) or 2 (skid)
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    m_cnt0 = 0;
    int    m_cnt1 = 0;

    function automatic bit m_rdy0();
        return (q0.size() == 0) || (out_ready === 1'b1);
    endfunction

    function automatic bit m_rdy1();
        return q1.size() < 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc0, acc1, stl0, stl1;
        beat_t b;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            acc0 = in_valid && m_rdy0();
            acc1 = in_valid && m_rdy1();
            stl0 = (q0.size() > 0) && !out_ready;
            stl1 = (q1.size() > 0) && !out_ready;
            b.c = in_ctrl;
            b.d = in_data;
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() > 0 && out_ready) void'(q0.pop_front());
                if (q1.size() > 0 && out_ready) void'(q1.pop_front());
                if (acc0) q0.push_back(b);
                if (acc1) q1.push_back(b);
            end
            if (stall_clr) m_cnt0 = 0;
            else if (stl0 && m_cnt0 < 3) m_cnt0++;
            if (stall_clr) m_cnt1 = 0;
            else if (stl1 && m_cnt1 < 15) m_cnt1++;
        end
    end

    // Return both stages to empty with cleared counters
    task automatic clean();
        in_valid  = 1'b0;
        flush     = 1'b1;
        stall_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        stall_clr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vecs++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL rst_valid0 got %0b want 0", out_valid0); end
        vecs++; if (out_valid1 !== 1'b0) begin errs++; $display("FAIL rst_valid1 got %0b want 0", out_valid1); end
        vecs++; if (out_ctrl0 !== '0) begin errs++; $display("FAIL rst_ctrl0 got %h want 0", out_ctrl0); end
        vecs++; if (out_data1 !== '0) begin errs++; $display("FAIL rst_data1 got %h want 0", out_data1); end
        vecs++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL rst_ready0 got %0b want 1", in_ready0); end
        vecs++; if (in_ready1 !== 1'b1) begin errs++; $display("FAIL rst_ready1 got %0b want 1", in_ready1); end
        vecs++; if (stall_cnt1 !== 4'd0) begin errs++; $display("FAIL rst_cnt1 got %0d want 0", stall_cnt1); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        clean();
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_data   = DW'(i);
            in_ctrl   = CW'(i + 1);
            #1;
            vecs++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL stream_ready got %0b want 1", in_ready0); end
            @(negedge clk);
            vecs++; if (out_valid0 !== 1'b1) begin errs++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid0); end
            vecs++; if (out_data0 !== DW'(i)) begin errs++; $display("FAIL stream_data[%0d] got %0d want %0d", i, out_data0, i); end
            vecs++; if (stall_cnt0 !== 2'd0) begin errs++; $display("FAIL stream_cnt[%0d] got %0d want 0", i, stall_cnt0); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        vecs++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL stream_drain got %0b want 0", out_valid0); end
    endtask

    task automatic test_backpressure();
        clean();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd1; in_ctrl = 9'd1;
        @(negedge clk);
        in_data = 16'd2; in_ctrl = 9'd2;
        #1;
        vecs++; if (out_data1 !== 16'd1) begin errs++; $display("FAIL bp_beat1 got %0d want 1", out_data1); end
        @(negedge clk);
        out_ready = 1'b0; in_data = 16'd3; in_ctrl = 9'd3;
        #1;
        vecs++; if (out_data1 !== 16'd2) begin errs++; $display("FAIL bp_main2 got %0d want 2", out_data1); end
        vecs++; if (in_ready1 !== 1'b1) begin errs++; $display("FAIL bp_ready_pre got %0b want 1", in_ready1); end
        @(negedge clk);
        in_data = 16'd4; in_ctrl = 9'd4;
        #1;
        vecs++; if (in_ready1 !== 1'b0) begin errs++; $display("FAIL bp_ready_full got %0b want 0", in_ready1); end
        vecs++; if (out_data1 !== 16'd2) begin errs++; $display("FAIL bp_hold2 got %0d want 2", out_data1); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        vecs++; if (out_data1 !== 16'd2 || out_valid1 !== 1'b1) begin errs++; $display("FAIL bp_out2 got %0d/%0b want 2/1", out_data1, out_valid1); end
        @(negedge clk);
        #1;
        vecs++; if (out_data1 !== 16'd3 || out_ctrl1 !== 9'd3) begin errs++; $display("FAIL bp_out3 got %0d/%0d want 3/3", out_data1, out_ctrl1); end
        vecs++; if (in_ready1 !== 1'b1) begin errs++; $display("FAIL bp_ready_free got %0b want 1", in_ready1); end
        @(negedge clk);
        vecs++; if (out_valid1 !== 1'b0) begin errs++; $display("FAIL bp_empty got %0b want 0", out_valid1); end
    endtask

    task automatic test_flush();
        clean();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 9'h0A5; in_data = 16'hAAAA;
        @(negedge clk);
        vecs++; if (out_ctrl0 !== 9'h0A5 || out_valid0 !== 1'b1) begin errs++; $display("FAIL fl_holdA got %h/%0b want 0a5/1", out_ctrl0, out_valid0); end
        flush = 1'b1; out_ready = 1'b1; in_ctrl = 9'h15A; in_data = 16'hBBBB;
        #1;
        vecs++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL fl_ready got %0b want 1", in_ready0); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        vecs++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0) begin errs++; $display("FAIL fl_u0 got %0b/%h want 0/0", out_valid0, out_ctrl0); end
        vecs++; if (out_valid1 !== 1'b0 || out_ctrl1 !== '0) begin errs++; $display("FAIL fl_u1 got %0b/%h want 0/0", out_valid1, out_ctrl1); end
        @(negedge clk);
        vecs++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errs++; $display("FAIL fl_noB got %0b/%0b want 0/0", out_valid0, out_valid1); end
    endtask

    task automatic test_bubble();
        clean();
        in_valid = 1'b0; in_ctrl = 9'h1FF; out_ready = 1'b0;
        @(negedge clk);
        vecs++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0) begin errs++; $display("FAIL bub_u0 got %0b/%h want 0/0", out_valid0, out_ctrl0); end
        vecs++; if (out_valid1 !== 1'b0 || out_ctrl1 !== '0) begin errs++; $display("FAIL bub_u1 got %0b/%h want 0/0", out_valid1, out_ctrl1); end
    endtask

    task automatic test_counter();
        int want;
        clean();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 9'h011; in_data = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        vecs++; if (stall_cnt0 !== 2'd0) begin errs++; $display("FAIL cnt_start got %0d want 0", stall_cnt0); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            want = (k > 3) ? 3 : k;
            vecs++; if (stall_cnt0 !== 2'(want)) begin errs++; $display("FAIL cnt_step[%0d] got %0d want %0d", k, stall_cnt0, want); end
        end
        stall_clr = 1'b1;
        @(negedge clk);
        stall_clr = 1'b0;
        vecs++; if (stall_cnt0 !== 2'd0) begin errs++; $display("FAIL cnt_clr got %0d want 0", stall_cnt0); end
    endtask

    task automatic test_async_reset();
        // a beat is still held and stalled from the counter scenario
        @(negedge clk);
        vecs++; if (out_valid0 !== 1'b1 || stall_cnt0 === 2'd0) begin errs++; $display("FAIL ar_pre got %0b/%0d want 1/nonzero", out_valid0, stall_cnt0); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errs++; $display("FAIL ar_valid got %0b/%0b want 0/0", out_valid0, out_valid1); end
        vecs++; if (stall_cnt0 !== 2'd0 || stall_cnt1 !== 4'd0) begin errs++; $display("FAIL ar_cnt got %0d/%0d want 0/0", stall_cnt0, stall_cnt1); end
        vecs++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin errs++; $display("FAIL ar_ready got %0b/%0b want 1/1", in_ready0, in_ready1); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [CW-1:0] ec;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_ctrl   = CW'($urandom);
            in_data   = DW'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            stall_clr = ($urandom_range(0, 15) == 0);
            #1;
            vecs++; if (out_valid0 !== (q0.size() > 0)) begin errs++; $display("FAIL rnd_valid0[%0d] got %0b want %0b", n, out_valid0, q0.size() > 0); end
            vecs++; if (in_ready0 !== m_rdy0()) begin errs++; $display("FAIL rnd_ready0[%0d] got %0b want %0b", n, in_ready0, m_rdy0()); end
            vecs++; if (stall_cnt0 !== 2'(m_cnt0)) begin errs++; $display("FAIL rnd_cnt0[%0d] got %0d want %0d", n, stall_cnt0, m_cnt0); end
            ec = (q0.size() > 0) ? q0[0].c : '0;
            vecs++; if (out_ctrl0 !== ec) begin errs++; $display("FAIL rnd_ctrl0[%0d] got %h want %h", n, out_ctrl0, ec); end
            if (q0.size() > 0) begin
                vecs++; if (out_data0 !== q0[0].d) begin errs++; $display("FAIL rnd_data0[%0d] got %h want %h", n, out_data0, q0[0].d); end
            end
            vecs++; if (out_valid1 !== (q1.size() > 0)) begin errs++; $display("FAIL rnd_valid1[%0d] got %0b want %0b", n, out_valid1, q1.size() > 0); end
            vecs++; if (in_ready1 !== m_rdy1()) begin errs++; $display("FAIL rnd_ready1[%0d] got %0b want %0b", n, in_ready1, m_rdy1()); end
            vecs++; if (stall_cnt1 !== 4'(m_cnt1)) begin errs++; $display("FAIL rnd_cnt1[%0d] got %0d want %0d", n, stall_cnt1, m_cnt1); end
            ec = (q1.size() > 0) ? q1[0].c : '0;
            vecs++; if (out_ctrl1 !== ec) begin errs++; $display("FAIL rnd_ctrl1[%0d] got %h want %h", n, out_ctrl1, ec); end
            if (q1.size() > 0) begin
                vecs++; if (out_data1 !== q1[0].d) begin errs++; $display("FAIL rnd_data1[%0d] got %h want %h", n, out_data1, q1[0].d); end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        stall_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_counter();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
